// File: rtl/eco32f_operand_fwd.sv
// eco32f_operand_fwd
// ID->EX operand register for the eco32f ALU. Tracks the destination, write
// enable, load and mul flags of the instructions in EX, MEM and WB, bypasses
// in-flight results into the operands, and requests a stall on load-use and
// mul-use hazards.
module eco32f_operand_fwd #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_stall,
    input  logic             ex_stall,
    input  logic             mem_stall,
    input  logic             id_flush,
    input  logic             ex_flush,
    input  logic             mem_flush,
    input  logic [AW-1:0]    id_rf_x_addr,
    input  logic [AW-1:0]    id_rf_y_addr,
    input  logic [WIDTH-1:0] id_rf_x,
    input  logic [WIDTH-1:0] id_rf_y,
    input  logic [AW-1:0]    id_rf_wb_addr,
    input  logic             id_rf_we,
    input  logic             id_op_load,
    input  logic             id_op_mul,
    input  logic [WIDTH-1:0] ex_alu_result,
    input  logic [WIDTH-1:0] mem_result,
    input  logic [WIDTH-1:0] wb_result,
    output logic [WIDTH-1:0] ex_rf_x,
    output logic [WIDTH-1:0] ex_rf_y,
    output logic             fwd_stall
);

    // Per-stage tracking state
    logic [AW-1:0]    ex_rd_q,   ex_rd_d;
    logic             ex_we_q,   ex_we_d;
    logic             ex_load_q, ex_load_d;
    logic             ex_mul_q,  ex_mul_d;
    logic [AW-1:0]    mem_rd_q,   mem_rd_d;
    logic             mem_we_q,   mem_we_d;
    logic             mem_load_q, mem_load_d;
    logic             mem_mul_q,  mem_mul_d;
    logic [AW-1:0]    wb_rd_q, wb_rd_d;
    logic             wb_we_q, wb_we_d;
    logic [WIDTH-1:0] ex_rf_x_q, ex_rf_x_d;
    logic [WIDTH-1:0] ex_rf_y_q, ex_rf_y_d;

    // An instruction being flushed out of its stage this cycle no longer
    // counts as a producer, so it is neither forwarded nor a hazard source.
    logic ex_live, mem_live, wb_live;
    assign ex_live  = ex_we_q  & ~ex_flush;
    assign mem_live = mem_we_q & ~mem_flush;
    assign wb_live  = wb_we_q;

    logic x_nz, y_nz;
    assign x_nz = (id_rf_x_addr != '0);
    assign y_nz = (id_rf_y_addr != '0);

    logic x_ex_hit, x_mem_hit, x_wb_hit;
    logic y_ex_hit, y_mem_hit, y_wb_hit;
    assign x_ex_hit  = ex_live  && (ex_rd_q  == id_rf_x_addr) && x_nz;
    assign x_mem_hit = mem_live && (mem_rd_q == id_rf_x_addr) && x_nz;
    assign x_wb_hit  = wb_live  && (wb_rd_q  == id_rf_x_addr) && x_nz;
    assign y_ex_hit  = ex_live  && (ex_rd_q  == id_rf_y_addr) && y_nz;
    assign y_mem_hit = mem_live && (mem_rd_q == id_rf_y_addr) && y_nz;
    assign y_wb_hit  = wb_live  && (wb_rd_q  == id_rf_y_addr) && y_nz;

    // Loads and muls have no result before WB, so they cannot feed EX/MEM bypass
    logic ex_late, mem_late;
    assign ex_late  = ex_load_q  | ex_mul_q;
    assign mem_late = mem_load_q | mem_mul_q;

    logic [WIDTH-1:0] op_x, op_y;

    // Operand select, youngest producer first, r0 forced to zero
    always_comb begin
        op_x = id_rf_x;
        if (x_ex_hit && !ex_late)        op_x = ex_alu_result;
        else if (x_mem_hit && !mem_late) op_x = mem_result;
        else if (x_wb_hit)               op_x = wb_result;
        else if (!x_nz)                  op_x = '0;

        op_y = id_rf_y;
        if (y_ex_hit && !ex_late)        op_y = ex_alu_result;
        else if (y_mem_hit && !mem_late) op_y = mem_result;
        else if (y_wb_hit)               op_y = wb_result;
        else if (!y_nz)                  op_y = '0;
    end

    // Hazard on raw matches: an older late producer in MEM stalls even if EX also matches
    assign fwd_stall = (x_ex_hit  & ex_late)  | (y_ex_hit  & ex_late) |
                       (x_mem_hit & mem_late) | (y_mem_hit & mem_late);

    // ID->EX advance: capture, bubble, or hold under ex_stall
    always_comb begin
        ex_rd_d   = ex_rd_q;
        ex_we_d   = ex_we_q;
        ex_load_d = ex_load_q;
        ex_mul_d  = ex_mul_q;
        ex_rf_x_d = ex_rf_x_q;
        ex_rf_y_d = ex_rf_y_q;
        if (!ex_stall) begin
            if (id_stall || id_flush) begin
                ex_rd_d   = '0;
                ex_we_d   = 1'b0;
                ex_load_d = 1'b0;
                ex_mul_d  = 1'b0;
            end else begin
                ex_rd_d   = id_rf_wb_addr;
                ex_we_d   = id_rf_we;
                ex_load_d = id_op_load;
                ex_mul_d  = id_op_mul;
                ex_rf_x_d = op_x;
                ex_rf_y_d = op_y;
            end
        end
    end

    // EX->MEM and MEM->WB advance; mem_stall holds both stages
    always_comb begin
        mem_rd_d   = mem_rd_q;
        mem_we_d   = mem_we_q;
        mem_load_d = mem_load_q;
        mem_mul_d  = mem_mul_q;
        wb_rd_d    = wb_rd_q;
        wb_we_d    = wb_we_q;
        if (!mem_stall) begin
            if (ex_stall || ex_flush) begin
                mem_rd_d   = '0;
                mem_we_d   = 1'b0;
                mem_load_d = 1'b0;
                mem_mul_d  = 1'b0;
            end else begin
                mem_rd_d   = ex_rd_q;
                mem_we_d   = ex_we_q;
                mem_load_d = ex_load_q;
                mem_mul_d  = ex_mul_q;
            end
            if (mem_flush) begin
                wb_rd_d = '0;
                wb_we_d = 1'b0;
            end else begin
                wb_rd_d = mem_rd_q;
                wb_we_d = mem_we_q;
            end
        end
    end

    // Pipeline state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_rd_q    <= '0;
            ex_we_q    <= 1'b0;
            ex_load_q  <= 1'b0;
            ex_mul_q   <= 1'b0;
            mem_rd_q   <= '0;
            mem_we_q   <= 1'b0;
            mem_load_q <= 1'b0;
            mem_mul_q  <= 1'b0;
            wb_rd_q    <= '0;
            wb_we_q    <= 1'b0;
            ex_rf_x_q  <= '0;
            ex_rf_y_q  <= '0;
        end else begin
            ex_rd_q    <= ex_rd_d;
            ex_we_q    <= ex_we_d;
            ex_load_q  <= ex_load_d;
            ex_mul_q   <= ex_mul_d;
            mem_rd_q   <= mem_rd_d;
            mem_we_q   <= mem_we_d;
            mem_load_q <= mem_load_d;
            mem_mul_q  <= mem_mul_d;
            wb_rd_q    <= wb_rd_d;
            wb_we_q    <= wb_we_d;
            ex_rf_x_q  <= ex_rf_x_d;
            ex_rf_y_q  <= ex_rf_y_d;
        end
    end

    assign ex_rf_x = ex_rf_x_q;
    assign ex_rf_y = ex_rf_y_q;

endmodule

// File: tb/tb_eco32f_operand_fwd.sv
// Directed bench for eco32f_operand_fwd. The bench plays the role of pipeline
// control (id_stall includes fwd_stall) and of the EX/MEM/WB datapath results.
module tb_eco32f_operand_fwd;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_stall, id_stall_ext, ex_stall, mem_stall;
    logic        id_flush, ex_flush, mem_flush;
    logic [4:0]  id_rf_x_addr, id_rf_y_addr, id_rf_wb_addr;
    logic [31:0] id_rf_x, id_rf_y;
    logic        id_rf_we, id_op_load, id_op_mul;
    logic [31:0] ex_alu_result, mem_result, wb_result;
    logic [31:0] ex_rf_x, ex_rf_y;
    logic        fwd_stall;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    assign id_stall = id_stall_ext | fwd_stall;

    eco32f_operand_fwd #(.WIDTH(32), .AW(5)) dut (
        .clk(clk), .rst(rst),
        .id_stall(id_stall), .ex_stall(ex_stall), .mem_stall(mem_stall),
        .id_flush(id_flush), .ex_flush(ex_flush), .mem_flush(mem_flush),
        .id_rf_x_addr(id_rf_x_addr), .id_rf_y_addr(id_rf_y_addr),
        .id_rf_x(id_rf_x), .id_rf_y(id_rf_y),
        .id_rf_wb_addr(id_rf_wb_addr), .id_rf_we(id_rf_we),
        .id_op_load(id_op_load), .id_op_mul(id_op_mul),
        .ex_alu_result(ex_alu_result), .mem_result(mem_result), .wb_result(wb_result),
        .ex_rf_x(ex_rf_x), .ex_rf_y(ex_rf_y), .fwd_stall(fwd_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [4:0] rd, input logic we, input logic ld, input logic mul,
                          input logic [4:0] xa, input logic [4:0] ya,
                          input logic [31:0] xv, input logic [31:0] yv);
        id_rf_wb_addr = rd;
        id_rf_we      = we;
        id_op_load    = ld;
        id_op_mul     = mul;
        id_rf_x_addr  = xa;
        id_rf_y_addr  = ya;
        id_rf_x       = xv;
        id_rf_y       = yv;
    endtask

    task automatic drain();
        set_id(5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);
        ex_alu_result = '0;
        mem_result    = '0;
        wb_result     = '0;
        repeat (3) tick();
    endtask

    initial begin
        rst = 1'b0;
        id_stall_ext = 1'b0; ex_stall = 1'b0; mem_stall = 1'b0;
        id_flush = 1'b0; ex_flush = 1'b0; mem_flush = 1'b0;
        ex_alu_result = '0; mem_result = '0; wb_result = '0;
        set_id(5'd3, 1'b1, 1'b1, 1'b0, 5'd3, 5'd3, 32'hAAAA, 32'hBBBB);

        // Reset state
        tick();
        chk("rst_x", ex_rf_x, 32'h0);
        chk("rst_y", ex_rf_y, 32'h0);
        chk("rst_stall", {31'b0, fwd_stall}, 32'h0);
        rst = 1'b1;
        drain();

        // add r3 <- r1(5) + r2(7)
        set_id(5'd3, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 32'd5, 32'd7);
        #1 chk("add3_stall", {31'b0, fwd_stall}, 32'h0);
        tick();
        chk("add3_x", ex_rf_x, 32'd5);
        chk("add3_y", ex_rf_y, 32'd7);
        // add r4 <- r3 + r0 : r3 bypassed from EX, r0 reads zero
        ex_alu_result = 32'd12;
        set_id(5'd4, 1'b1, 1'b0, 1'b0, 5'd3, 5'd0, 32'hDEAD, 32'h99);
        #1 chk("add4_stall", {31'b0, fwd_stall}, 32'h0);
        tick();
        chk("ex_fwd_x", ex_rf_x, 32'd12);
        chk("r0_y", ex_rf_y, 32'h0);
        // r3 in MEM, r4 in EX
        ex_alu_result = 32'd13;
        mem_result    = 32'd12;
        set_id(5'd0, 1'b0, 1'b0, 1'b0, 5'd3, 5'd4, 32'hBAD, 32'hBAD2);
        tick();
        chk("mem_fwd_x", ex_rf_x, 32'd12);
        chk("ex_fwd_y", ex_rf_y, 32'd13);
        // r3 in WB, r4 in MEM
        ex_alu_result = 32'h0;
        mem_result    = 32'd13;
        wb_result     = 32'd12;
        set_id(5'd0, 1'b0, 1'b0, 1'b0, 5'd3, 5'd4, 32'hBAD, 32'hBAD2);
        tick();
        chk("wb_fwd_x", ex_rf_x, 32'd12);
        chk("mem_fwd_y", ex_rf_y, 32'd13);
        // r4 in WB now, then retired: no forwarding past WB
        set_id(5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);
        tick();
        wb_result = 32'h777;
        set_id(5'd0, 1'b0, 1'b0, 1'b0, 5'd4, 5'd3, 32'hABC, 32'hC);
        tick();
        chk("past_wb_x", ex_rf_x, 32'hABC);
        chk("past_wb_y", ex_rf_y, 32'hC);
        drain();

        // ldw r5 then add r6 <- r5 + r5 : two stall cycles
        set_id(5'd5, 1'b1, 1'b1, 1'b0, 5'd1, 5'd0, 32'h100, 32'h0);
        tick();
        chk("ld_x", ex_rf_x, 32'h100);
        set_id(5'd6, 1'b1, 1'b0, 1'b0, 5'd5, 5'd5, 32'hBAD, 32'hBAD);
        #1 chk("lduse_stall1", {31'b0, fwd_stall}, 32'h1);
        tick();
        chk("lduse_stall2", {31'b0, fwd_stall}, 32'h1);
        chk("bubble_hold_x", ex_rf_x, 32'h100);
        tick();
        chk("lduse_stall3", {31'b0, fwd_stall}, 32'h0);
        chk("bubble_hold_x2", ex_rf_x, 32'h100);
        wb_result = 32'h55AA;
        tick();
        chk("ld_wb_x", ex_rf_x, 32'h55AA);
        chk("ld_wb_y", ex_rf_y, 32'h55AA);
        drain();

        // mul r7, nop, add r8 <- r7 : one stall cycle
        set_id(5'd7, 1'b1, 1'b0, 1'b1, 5'd1, 5'd2, 32'd3, 32'd4);
        tick();
        set_id(5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);
        #1 chk("nop_stall", {31'b0, fwd_stall}, 32'h0);
        tick();
        set_id(5'd8, 1'b1, 1'b0, 1'b0, 5'd7, 5'd0, 32'hBAD, 32'h5);
        #1 chk("muluse_stall1", {31'b0, fwd_stall}, 32'h1);
        tick();
        chk("muluse_stall2", {31'b0, fwd_stall}, 32'h0);
        wb_result = 32'd12;
        tick();
        chk("mul_wb_x", ex_rf_x, 32'd12);
        chk("mul_wb_y", ex_rf_y, 32'h0);
        drain();

        // mul in EX, dependent on source Y directly behind
        set_id(5'd7, 1'b1, 1'b0, 1'b1, 5'd1, 5'd2, 32'd3, 32'd4);
        tick();
        set_id(5'd9, 1'b1, 1'b0, 1'b0, 5'd0, 5'd7, 32'h0, 32'hBAD);
        #1 chk("mul_ex_y_stall", {31'b0, fwd_stall}, 32'h1);
        drain();

        // Writes to r0 in EX/MEM/WB (add/mul/ld), ID reads r0
        set_id(5'd0, 1'b1, 1'b1, 1'b0, 5'd1, 5'd2, 32'h1, 32'h2);
        tick();
        set_id(5'd0, 1'b1, 1'b0, 1'b1, 5'd1, 5'd2, 32'h1, 32'h2);
        tick();
        set_id(5'd0, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 32'h1, 32'h2);
        tick();
        set_id(5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'h77, 32'h88);
        ex_alu_result = 32'h11; mem_result = 32'h22; wb_result = 32'h33;
        #1 chk("r0_stall", {31'b0, fwd_stall}, 32'h0);
        tick();
        chk("r0_x", ex_rf_x, 32'h0);
        chk("r0_y2", ex_rf_y, 32'h0);
        drain();

        // r9 in EX (0x11) and MEM (0x22): youngest wins
        set_id(5'd9, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 32'h1, 32'h2);
        tick();
        tick();
        set_id(5'd0, 1'b0, 1'b0, 1'b0, 5'd9, 5'd9, 32'hBAD, 32'hBAD);
        ex_alu_result = 32'h11; mem_result = 32'h22;
        tick();
        chk("youngest_x", ex_rf_x, 32'h11);
        chk("youngest_y", ex_rf_y, 32'h11);
        drain();

        // ld r10 in MEM under a non-load r10 in EX still stalls
        set_id(5'd10, 1'b1, 1'b1, 1'b0, 5'd1, 5'd2, 32'h1, 32'h2);
        tick();
        set_id(5'd10, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 32'h1, 32'h2);
        #1 chk("indep_stall", {31'b0, fwd_stall}, 32'h0);
        tick();
        set_id(5'd0, 1'b0, 1'b0, 1'b0, 5'd10, 5'd0, 32'hBAD, 32'h0);
        #1 chk("older_mem_ld_stall", {31'b0, fwd_stall}, 32'h1);
        drain();

        // ex_flush on producer r11: dependent uses register file
        set_id(5'd11, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 32'h1, 32'h2);
        tick();
        ex_flush = 1'b1;
        ex_alu_result = 32'h999;
        set_id(5'd0, 1'b0, 1'b0, 1'b0, 5'd11, 5'd0, 32'h444, 32'h0);
        tick();
        ex_flush = 1'b0;
        chk("exflush_x", ex_rf_x, 32'h444);
        mem_result = 32'h888;
        tick();
        chk("exflush_mem_x", ex_rf_x, 32'h444);
        // ex_stall holds operands
        ex_stall = 1'b1;
        set_id(5'd0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd0, 32'h1234, 32'h0);
        tick();
        chk("exstall_hold_x", ex_rf_x, 32'h444);
        ex_stall = 1'b0;
        drain();

        // id_flush on producer r14: becomes a bubble, never forwarded
        id_flush = 1'b1;
        set_id(5'd14, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 32'h1, 32'h2);
        tick();
        id_flush = 1'b0;
        ex_alu_result = 32'h999;
        set_id(5'd0, 1'b0, 1'b0, 1'b0, 5'd14, 5'd0, 32'h66, 32'h0);
        tick();
        chk("idflush_x", ex_rf_x, 32'h66);
        drain();

        // Reset asserted mid-stall
        set_id(5'd12, 1'b1, 1'b1, 1'b0, 5'd1, 5'd2, 32'h321, 32'h654);
        tick();
        chk("pre_rst_x", ex_rf_x, 32'h321);
        set_id(5'd0, 1'b0, 1'b0, 1'b0, 5'd12, 5'd0, 32'hBAD, 32'h0);
        #1 chk("pre_rst_stall", {31'b0, fwd_stall}, 32'h1);
        rst = 1'b0;
        #1;
        chk("mid_rst_x", ex_rf_x, 32'h0);
        chk("mid_rst_y", ex_rf_y, 32'h0);
        chk("mid_rst_stall", {31'b0, fwd_stall}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
